// File: rtl/draw_pkg.sv
// Shared definitions for the raster draw datapath.
// Holds the opcode encodings, the controller state encoding, default field
// widths and a helper that packs an instruction word at those default widths.
package draw_pkg;

    // Default field widths; the datapath is parametrised but these are the
    // values the frame-buffer writer and controller are built against.
    localparam int X_W_D      = 8;
    localparam int Y_W_D      = 7;
    localparam int COLOUR_W_D = 3;
    localparam int OPCODE_W_D = 4;
    localparam int INSTR_W_D  = OPCODE_W_D + 2 * X_W_D + 2 * Y_W_D + COLOUR_W_D;

    // Opcodes; every encoding above OP_CLEAR is illegal.
    localparam int OP_NOP   = 0;
    localparam int OP_PIXEL = 1;
    localparam int OP_FILL  = 2;
    localparam int OP_CLEAR = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Packs {opcode, x0, y0, w, h, colour}, MSB..LSB, at the default widths.
    function automatic logic [INSTR_W_D-1:0] pack_instr(
        input logic [OPCODE_W_D-1:0] op,
        input logic [X_W_D-1:0]      x0,
        input logic [Y_W_D-1:0]      y0,
        input logic [X_W_D-1:0]      w,
        input logic [Y_W_D-1:0]      h,
        input logic [COLOUR_W_D-1:0] c
    );
        return {op, x0, y0, w, h, c};
    endfunction

endpackage

// File: rtl/raster_counter.sv
// Nested x/y raster counter.
// Loads a start corner and an exclusive end corner, then walks row-major
// (x fastest) one position per step. Counters are one bit wider than the
// coordinate fields so start+length never wraps.
// Ports:
//   clock, reset          clock and asynchronous active-high reset
//   load                  capture x_start/y_start/x_end/y_end
//   step                  advance to the next position
//   x_start, y_start      first position
//   x_end, y_end          exclusive end (start + length)
//   x_cnt, y_cnt          current position
//   last                  current position is the final one of the rectangle
module raster_counter #(
    parameter int X_W = 8,
    parameter int Y_W = 7
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic         step,
    input  logic [X_W:0] x_start,
    input  logic [Y_W:0] y_start,
    input  logic [X_W:0] x_end,
    input  logic [Y_W:0] y_end,
    output logic [X_W:0] x_cnt,
    output logic [Y_W:0] y_cnt,
    output logic         last
);

    localparam logic [X_W:0] X_ONE = {{X_W{1'b0}}, 1'b1};
    localparam logic [Y_W:0] Y_ONE = {{Y_W{1'b0}}, 1'b1};

    logic [X_W:0] x_q, x_d, x_start_q, x_start_d, x_end_q, x_end_d;
    logic [Y_W:0] y_q, y_d, y_end_q, y_end_d;
    logic         row_end;

    assign row_end = (x_q + X_ONE) == x_end_q;
    assign last    = row_end && ((y_q + Y_ONE) == y_end_q);
    assign x_cnt   = x_q;
    assign y_cnt   = y_q;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        x_d       = x_q;
        y_d       = y_q;
        x_start_d = x_start_q;
        x_end_d   = x_end_q;
        y_end_d   = y_end_q;
        if (load) begin
            x_d       = x_start;
            y_d       = y_start;
            x_start_d = x_start;
            x_end_d   = x_end;
            y_end_d   = y_end;
        end else if (step) begin
            if (row_end) begin
                x_d = x_start_q;
                y_d = y_q + Y_ONE;
            end else begin
                x_d = x_q + X_ONE;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x_q       <= '0;
            y_q       <= '0;
            x_start_q <= '0;
            x_end_q   <= '0;
            y_end_q   <= '0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            x_start_q <= x_start_d;
            x_end_q   <= x_end_d;
            y_end_q   <= y_end_d;
        end
    end

endmodule

// File: rtl/raster_draw_datapath.sv
// Raster draw datapath.
// Decodes one packed instruction per start pulse (NOP, PIXEL, FILL, CLEAR)
// and emits a stream of clipped x/y/colour plot strobes with a plot/plot_ready
// handshake. Reports the count of accepted pixels (saturating) and whether the
// opcode was illegal when the instruction completes.
// Ports:
//   clock, reset   clock and asynchronous active-high reset
//   start          request, sampled only while finished=1
//   instruction    {opcode, x0, y0, w, h, colour}, MSB..LSB
//   plot_ready     writer accepts the current pixel this cycle
//   x, y, colour   pixel being presented
//   plot           x/y/colour valid, held until plot_ready
//   finished       idle and ready for start
//   result         pixels accepted by the last instruction
//   error          last instruction had an illegal opcode
module raster_draw_datapath
    import draw_pkg::*;
#(
    parameter int X_W      = X_W_D,
    parameter int Y_W      = Y_W_D,
    parameter int COLOUR_W = COLOUR_W_D,
    parameter int OPCODE_W = OPCODE_W_D,
    parameter int RESULT_W = 16,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int INSTR_W  = OPCODE_W + 2 * X_W + 2 * Y_W + COLOUR_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [INSTR_W-1:0]  instruction,
    input  logic                plot_ready,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                finished,
    output logic [RESULT_W-1:0] result,
    output logic                error
);

    // Field offsets inside the instruction word.
    localparam int H_LSB  = COLOUR_W;
    localparam int W_LSB  = H_LSB + Y_W;
    localparam int Y0_LSB = W_LSB + X_W;
    localparam int X0_LSB = Y0_LSB + Y_W;
    localparam int OP_LSB = X0_LSB + X_W;

    localparam logic [X_W:0]      X_ONE = {{X_W{1'b0}}, 1'b1};
    localparam logic [Y_W:0]      Y_ONE = {{Y_W{1'b0}}, 1'b1};
    localparam logic [RESULT_W-1:0] R_ONE = {{(RESULT_W-1){1'b0}}, 1'b1};

    logic [OPCODE_W-1:0] op_in;
    logic [X_W-1:0]      x0_in, w_in;
    logic [Y_W-1:0]      y0_in, h_in;

    assign op_in = instruction[OP_LSB +: OPCODE_W];
    assign x0_in = instruction[X0_LSB +: X_W];
    assign y0_in = instruction[Y0_LSB +: Y_W];
    assign w_in  = instruction[W_LSB +: X_W];
    assign h_in  = instruction[H_LSB +: Y_W];

    state_e              state_q, state_d;
    logic [COLOUR_W-1:0] colour_q, colour_d;
    logic                empty_q, empty_d;      // instruction emits no pixels
    logic                illegal_q, illegal_d;
    logic [RESULT_W-1:0] count_q, count_d;
    logic [RESULT_W-1:0] result_q, result_d;
    logic                error_q, error_d;

    logic         load, step, plot_c;
    logic [X_W:0] x_start, x_end, x_cnt;
    logic [Y_W:0] y_start, y_end, y_cnt;
    logic         last, in_bounds;

    raster_counter #(.X_W(X_W), .Y_W(Y_W)) u_counter (
        .clock   (clock),
        .reset   (reset),
        .load    (load),
        .step    (step),
        .x_start (x_start),
        .y_start (y_start),
        .x_end   (x_end),
        .y_end   (y_end),
        .x_cnt   (x_cnt),
        .y_cnt   (y_cnt),
        .last    (last)
    );

    assign in_bounds = (x_cnt < (X_W+1)'(SCREEN_W)) && (y_cnt < (Y_W+1)'(SCREEN_H));

    // Decode the incoming instruction into a start corner and exclusive end.
    always_comb begin
        x_start = {1'b0, x0_in};
        y_start = {1'b0, y0_in};
        x_end   = {1'b0, x0_in} + X_ONE;
        y_end   = {1'b0, y0_in} + Y_ONE;
        if (op_in == OPCODE_W'(OP_FILL)) begin
            x_end = {1'b0, x0_in} + {1'b0, w_in};
            y_end = {1'b0, y0_in} + {1'b0, h_in};
        end else if (op_in == OPCODE_W'(OP_CLEAR)) begin
            x_start = '0;
            y_start = '0;
            x_end   = (X_W+1)'(SCREEN_W);
            y_end   = (Y_W+1)'(SCREEN_H);
        end
    end

    always_comb begin
        state_d   = state_q;
        colour_d  = colour_q;
        empty_d   = empty_q;
        illegal_d = illegal_q;
        count_d   = count_q;
        result_d  = result_q;
        error_d   = error_q;
        load      = 1'b0;
        step      = 1'b0;
        plot_c    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_d   = ST_RUN;
                    colour_d  = instruction[COLOUR_W-1:0];
                    illegal_d = op_in > OPCODE_W'(OP_CLEAR);
                    empty_d   = (op_in == OPCODE_W'(OP_NOP)) || (op_in > OPCODE_W'(OP_CLEAR)) ||
                                ((op_in == OPCODE_W'(OP_FILL)) && ((w_in == '0) || (h_in == '0)));
                    count_d   = '0;
                end
            end
            ST_RUN: begin
                if (empty_q) begin
                    state_d = ST_IDLE;
                end else if (in_bounds) begin
                    plot_c = 1'b1;
                    if (plot_ready) begin
                        step = 1'b1;
                        if (count_q != '1) count_d = count_q + R_ONE;
                        if (last) state_d = ST_IDLE;
                    end
                end else begin
                    // Clipped position: spend one cycle with plot low and move on.
                    step = 1'b1;
                    if (last) state_d = ST_IDLE;
                end
                if (state_d == ST_IDLE) begin
                    result_d = count_d;
                    error_d  = illegal_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            colour_q  <= '0;
            empty_q   <= 1'b0;
            illegal_q <= 1'b0;
            count_q   <= '0;
            result_q  <= '0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            colour_q  <= colour_d;
            empty_q   <= empty_d;
            illegal_q <= illegal_d;
            count_q   <= count_d;
            result_q  <= result_d;
            error_q   <= error_d;
        end
    end

    assign x        = x_cnt[X_W-1:0];
    assign y        = y_cnt[Y_W-1:0];
    assign colour   = colour_q;
    assign plot     = plot_c;
    assign finished = (state_q == ST_IDLE);
    assign result   = result_q;
    assign error    = error_q;

endmodule

// File: tb/tb_raster_draw_datapath.sv
// Testbench for raster_draw_datapath: directed instructions with hand-computed
// pixel streams and completion values pushed into scoreboard queues, checked
// by a separate monitor whenever the DUT presents a pixel or completes.
module tb_raster_draw_datapath;
    import draw_pkg::*;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 start;
    logic [INSTR_W_D-1:0] instruction;
    logic                 plot_ready;
    logic [X_W_D-1:0]     x;
    logic [Y_W_D-1:0]     y;
    logic [COLOUR_W_D-1:0] colour;
    logic                 plot;
    logic                 finished;
    logic [15:0]          result;
    logic                 error;

    int total = 0;
    int bad   = 0;
    int ready_mode = 0;   // 0: tied high, 1: toggling, 2: held low

    logic [17:0] px_q[$];    // {x, y, colour}
    logic [16:0] done_q[$];  // {result, error}

    raster_draw_datapath dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .instruction (instruction),
        .plot_ready  (plot_ready),
        .x           (x),
        .y           (y),
        .colour      (colour),
        .plot        (plot),
        .finished    (finished),
        .result      (result),
        .error       (error)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // plot_ready driver, updated 2 time units after each rising edge.
    initial begin
        plot_ready = 1'b1;
        forever begin
            @(posedge clock);
            #2;
            case (ready_mode)
                1:       plot_ready = ~plot_ready;
                2:       plot_ready = 1'b0;
                default: plot_ready = 1'b1;
            endcase
        end
    end

    // Monitor: samples on the falling edge, pops expectations on acceptance
    // and on each rise of finished, and checks stability while stalled.
    initial begin
        logic        prev_fin = 1'b1;
        logic        hold     = 1'b0;
        logic [17:0] held     = '0;
        logic [17:0] exp_px;
        logic [16:0] exp_done;
        forever begin
            @(negedge clock);
            if (reset) begin
                hold     = 1'b0;
                prev_fin = finished;
            end else begin
                if (hold) begin
                    check("hold_plot", 64'(plot), 64'd1);
                    check("hold_data", 64'({x, y, colour}), 64'(held));
                end
                if (plot && plot_ready) begin
                    if (px_q.size() == 0) check("extra_plot", 64'd1, 64'd0);
                    else begin
                        exp_px = px_q.pop_front();
                        check("pixel", 64'({x, y, colour}), 64'(exp_px));
                    end
                end
                hold = plot && !plot_ready;
                held = {x, y, colour};
                if (finished && !prev_fin) begin
                    if (done_q.size() == 0) check("extra_done", 64'd1, 64'd0);
                    else begin
                        exp_done = done_q.pop_front();
                        check("done_result_error", 64'({result, error}), 64'(exp_done));
                    end
                end
                prev_fin = finished;
            end
        end
    end

    // Waits (bounded) for finished, then presents one instruction for one cycle.
    task automatic issue(input logic [INSTR_W_D-1:0] instr);
        int g = 0;
        while (!finished && g < 30000) begin
            @(posedge clock); #1; g++;
        end
        if (!finished) check("issue_timeout", 64'd0, 64'd1);
        start = 1'b1;
        instruction = instr;
        @(posedge clock); #1;
        start = 1'b0;
        instruction = '0;
    endtask

    // Called in cycle 1 (one edge after start); returns in the cycle finished is high.
    task automatic wait_done(input int exp_cycles);
        int n = 1;
        while (!finished && n < 30000) begin
            @(posedge clock); #1; n++;
        end
        if (!finished) check("done_timeout", 64'd0, 64'd1);
        else if (exp_cycles > 0) check("latency", 64'(n), 64'(exp_cycles));
    endtask

    initial begin
        int plots;
        reset = 1'b1;
        start = 1'b0;
        instruction = '0;
        #2;
        check("rst_x", 64'(x), 64'd0);
        check("rst_y", 64'(y), 64'd0);
        check("rst_colour", 64'(colour), 64'd0);
        check("rst_plot", 64'(plot), 64'd0);
        check("rst_finished", 64'(finished), 64'd1);
        check("rst_result", 64'(result), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;

        // PIXEL (10,20) colour 6.
        px_q.push_back({8'd10, 7'd20, 3'd6});
        done_q.push_back({16'd1, 1'b0});
        issue(pack_instr(4'(OP_PIXEL), 8'd10, 7'd20, 8'd0, 7'd0, 3'd6));
        check("pixel_plot_cycle1", 64'(plot), 64'd1);
        wait_done(2);

        // Reset mid-FILL while plot is held high.
        ready_mode = 2;
        @(posedge clock); #1;
        issue(pack_instr(4'(OP_FILL), 8'd0, 7'd0, 8'd3, 7'd2, 3'd2));
        check("mid_fill_plot", 64'(plot), 64'd1);
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        check("reset_plot", 64'(plot), 64'd0);
        check("reset_finished", 64'(finished), 64'd1);
        check("reset_result", 64'(result), 64'd0);
        ready_mode = 0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;
        plots = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1;
            if (plot) plots++;
        end
        check("no_plot_after_reset", 64'(plots), 64'd0);

        // FILL (0,0) 3x2 with plot_ready toggling.
        ready_mode = 1;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 3; c++)
                px_q.push_back({8'(c), 7'(r), 3'd3});
        done_q.push_back({16'd6, 1'b0});
        issue(pack_instr(4'(OP_FILL), 8'd0, 7'd0, 8'd3, 7'd2, 3'd3));
        wait_done(0);
        ready_mode = 0;
        @(posedge clock); #1;

        // FILL (158,118) 4x4 crossing the bottom-right corner.
        px_q.push_back({8'd158, 7'd118, 3'd5});
        px_q.push_back({8'd159, 7'd118, 3'd5});
        px_q.push_back({8'd158, 7'd119, 3'd5});
        px_q.push_back({8'd159, 7'd119, 3'd5});
        done_q.push_back({16'd4, 1'b0});
        issue(pack_instr(4'(OP_FILL), 8'd158, 7'd118, 8'd4, 7'd4, 3'd5));
        wait_done(17);

        // Illegal opcode, then NOP clears error.
        done_q.push_back({16'd0, 1'b1});
        issue(pack_instr(4'd9, 8'd1, 7'd1, 8'd1, 7'd1, 3'd7));
        wait_done(2);
        done_q.push_back({16'd0, 1'b0});
        issue(pack_instr(4'(OP_NOP), 8'd0, 7'd0, 8'd0, 7'd0, 3'd0));
        wait_done(2);

        // Empty FILL then CLEAR colour 1, back-to-back.
        done_q.push_back({16'd0, 1'b0});
        issue(pack_instr(4'(OP_FILL), 8'd5, 7'd5, 8'd0, 7'd3, 3'd4));
        wait_done(2);
        for (int r = 0; r < 120; r++)
            for (int c = 0; c < 160; c++)
                px_q.push_back({8'(c), 7'(r), 3'd1});
        done_q.push_back({16'd19200, 1'b0});
        issue(pack_instr(4'(OP_CLEAR), 8'd9, 7'd9, 8'd9, 7'd9, 3'd1));
        wait_done(19201);

        repeat (3) @(posedge clock);
        #1;
        check("px_queue_drained", 64'(px_q.size()), 64'd0);
        check("done_queue_drained", 64'(done_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
